// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - bounded nonce search controller driving one SHA-256 core
// Walks [nonce_start..nonce_end] (wrapping), one outstanding core job, leading-zero check.
module nonce_scheduler #(
  parameter int NONCE_W = 32,
  parameter int DIFF_W  = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NONCE_W-1:0] i_nonce_start,
  input  logic [NONCE_W-1:0] i_nonce_end,
  input  logic [DIFF_W-1:0]  i_difficulty,
  input  logic               i_core_ready,
  output logic               o_core_go,
  output logic [NONCE_W-1:0] o_core_nonce,
  input  logic               i_core_done,
  input  logic [255:0]       i_hash,
  output logic               o_busy,
  output logic               o_found,
  output logic               o_exhausted,
  output logic [NONCE_W-1:0] o_result_nonce,
  output logic [NONCE_W-1:0] o_hashes_tried,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT      = 3'd3,
    S_CHECK     = 3'd4,
    S_FOUND     = 3'd5,
    S_EXHAUSTED = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [NONCE_W-1:0] r_cur;
  logic [NONCE_W-1:0] r_end;
  logic [DIFF_W-1:0]  r_diff;
  logic [255:0]       r_hash;
  logic               r_busy;
  logic               r_found;
  logic               r_exhausted;
  logic [NONCE_W-1:0] r_result_nonce;
  logic [NONCE_W-1:0] r_hashes_tried;
  logic [255:0]       w_mask;
  logic               w_match;
  logic               w_last;

  // Mask covers the top r_diff bits; difficulty 0 gives an empty mask and always matches.
  assign w_mask  = ~({256{1'b1}} >> r_diff);
  assign w_match = ((r_hash & w_mask) == '0);
  assign w_last  = (r_cur == r_end);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (i_start) w_next = S_LOAD;
      S_LOAD:      w_next = S_ISSUE;
      S_ISSUE:     if (i_core_ready) w_next = S_WAIT;
      S_WAIT:      if (i_core_done) w_next = S_CHECK;
      S_CHECK: begin
        if (w_match)     w_next = S_FOUND;
        else if (w_last) w_next = S_EXHAUSTED;
        else             w_next = S_ISSUE;
      end
      S_FOUND:     if (i_start) w_next = S_LOAD;
      S_EXHAUSTED: if (i_start) w_next = S_LOAD;
      default:     w_next = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_cur          <= '0;
      r_end          <= '0;
      r_diff         <= '0;
      r_hash         <= '0;
      r_busy         <= 1'b0;
      r_found        <= 1'b0;
      r_exhausted    <= 1'b0;
      r_result_nonce <= '0;
      r_hashes_tried <= '0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next == S_LOAD) || (w_next == S_ISSUE) ||
                     (w_next == S_WAIT) || (w_next == S_CHECK);
      r_found     <= (w_next == S_FOUND);
      r_exhausted <= (w_next == S_EXHAUSTED);
      if (!i_abort) begin
        case (r_state)
          S_LOAD: begin
            r_cur          <= i_nonce_start;
            r_end          <= i_nonce_end;
            r_diff         <= i_difficulty;
            r_hashes_tried <= '0;
          end
          S_WAIT: if (i_core_done) r_hash <= i_hash;
          S_CHECK: begin
            if (r_hashes_tried != '1) r_hashes_tried <= r_hashes_tried + NONCE_W'(1);
            if (w_match)      r_result_nonce <= r_cur;
            else if (!w_last) r_cur <= r_cur + NONCE_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // The launch pulse is combinational so the core sees it in the ISSUE cycle that has ready.
  assign o_core_go      = (r_state == S_ISSUE) && i_core_ready && !i_abort;
  assign o_core_nonce   = r_cur;
  assign o_busy         = r_busy;
  assign o_found        = r_found;
  assign o_exhausted    = r_exhausted;
  assign o_result_nonce = r_result_nonce;
  assign o_hashes_tried = r_hashes_tried;
  assign o_state        = r_state;

endmodule
